// File: rtl/ixc_gfifo_arb_if.sv
// Handshake, data and credit bundle between the GFIFO requesters/host side
// and the round-robin output arbiter.
interface ixc_gfifo_arb_if #(
    parameter int NREQ = 4,
    parameter int DW   = 64,
    parameter int CW   = 9
);
    localparam int SW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]    req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_last;
    logic [NREQ-1:0]    req_ready;
    logic               out_valid;
    logic [DW-1:0]      out_data;
    logic [SW-1:0]      out_src;
    logic               out_last;
    logic               out_ready;
    logic               credit_ret;
    logic [CW-1:0]      credit_num;
    logic [CW-1:0]      credit_cnt;
    logic [63:0]        wr_cnt;
    logic               credit_err;

    modport slave (
        input  req_valid, req_data, req_last, out_ready, credit_ret, credit_num,
        output req_ready, out_valid, out_data, out_src, out_last,
               credit_cnt, wr_cnt, credit_err
    );

    modport master (
        output req_valid, req_data, req_last, out_ready, credit_ret, credit_num,
        input  req_ready, out_valid, out_data, out_src, out_last,
               credit_cnt, wr_cnt, credit_err
    );
endinterface

// File: rtl/ixc_gfifo_arb.sv
// Round-robin message arbiter for the shared GFIFO output channel, with
// host credit metering and a free-running 64-bit transferred-word count.
module ixc_gfifo_arb #(
    parameter int NREQ    = 4,
    parameter int DW      = 64,
    parameter int CREDITS = 256,
    parameter int CW      = 9
) (
    input  logic            clk,
    input  logic            rst,
    ixc_gfifo_arb_if.slave  bus
);
    localparam int SW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   grant_q, grant_d;
    logic [SW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [SW-1:0]   pick;
    logic            pick_vld;

    logic            out_valid_q, out_valid_d;
    logic [DW-1:0]   out_data_q, out_data_d;
    logic [SW-1:0]   out_src_q, out_src_d;
    logic            out_last_q, out_last_d;

    logic [CW-1:0]   credit_q, credit_d;
    logic [63:0]     wr_cnt_q, wr_cnt_d;
    logic            err_q, err_d;

    logic            load_ok;
    logic            accept;
    logic [NREQ-1:0] ready;
    logic [DW-1:0]   grant_data;
    logic            grant_last;
    logic [CW:0]     credit_sum;

    // First valid requester at or after rr_ptr; the downward scan lets the
    // smallest offset win.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            int unsigned idx;
            idx = int'(rr_ptr_q) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (bus.req_valid[idx]) begin
                pick     = SW'(idx);
                pick_vld = 1'b1;
            end
        end
    end

    assign grant_data = bus.req_data[int'(grant_q)*DW +: DW];
    assign grant_last = bus.req_last[grant_q];
    assign load_ok    = (!out_valid_q || bus.out_ready) && (credit_q != '0);

    always_comb begin
        ready = '0;
        if (state_q == BUSY && bus.req_valid[grant_q] && load_ok) begin
            ready[grant_q] = 1'b1;
        end
    end

    assign accept = |ready;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    grant_d = pick;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (accept && grant_last) begin
                    state_d  = IDLE;
                    rr_ptr_d = (grant_q == SW'(NREQ - 1)) ? '0 : grant_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output register: a fresh load wins over draining the current word.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        out_last_d  = out_last_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = grant_data;
            out_src_d   = grant_q;
            out_last_d  = grant_last;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Consume and return fold into one net update; one extra bit keeps the
    // overflow visible before saturation.
    always_comb begin
        credit_sum = {1'b0, credit_q} - {{CW{1'b0}}, accept}
                   + (bus.credit_ret ? {1'b0, bus.credit_num} : '0);
        credit_d   = credit_q;
        err_d      = err_q;
        if (credit_sum > (CW+1)'(CREDITS)) begin
            credit_d = CW'(CREDITS);
            err_d    = 1'b1;
        end else begin
            credit_d = credit_sum[CW-1:0];
        end
        wr_cnt_d = wr_cnt_q + {63'd0, out_valid_q & bus.out_ready};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            out_last_q  <= 1'b0;
            credit_q    <= CW'(CREDITS);
            wr_cnt_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            out_last_q  <= out_last_d;
            credit_q    <= credit_d;
            wr_cnt_q    <= wr_cnt_d;
            err_q       <= err_d;
        end
    end

    assign bus.req_ready  = ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_src    = out_src_q;
    assign bus.out_last   = out_last_q;
    assign bus.credit_cnt = credit_q;
    assign bus.wr_cnt     = wr_cnt_q;
    assign bus.credit_err = err_q;

endmodule

// File: tb/tb_ixc_gfifo_arb.sv
// Randomized and directed bench for ixc_gfifo_arb, checked every cycle
// against a message-level reference model of the arbiter.
module tb_ixc_gfifo_arb;
    localparam int NREQ    = 4;
    localparam int DW      = 32;
    localparam int CREDITS = 8;
    localparam int CW      = 4;
    localparam int SW      = $clog2(NREQ);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ixc_gfifo_arb_if #(.NREQ(NREQ), .DW(DW), .CW(CW)) bus ();

    ixc_gfifo_arb #(.NREQ(NREQ), .DW(DW), .CREDITS(CREDITS), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vecCount  = 0;
    int missCount = 0;

    logic            rstIn;
    logic [NREQ-1:0] vIn, lIn;
    logic            oIn, crIn;
    logic [CW-1:0]   cnIn;
    logic [DW-1:0]   dataIn [NREQ];

    // Reference model state: message ownership, output slot and counters.
    bit            mBusy;
    int            mOwner, mPtr;
    bit            mOv, mOl;
    logic [DW-1:0] mOd;
    int            mOs;
    int            mCred;
    logic [63:0]   mWr;
    bit            mErr;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecCount++;
        if (obs !== exp) begin
            missCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelReset();
        mBusy = 0; mOwner = 0; mPtr = 0;
        mOv = 0; mOl = 0; mOd = '0; mOs = 0;
        mCred = CREDITS; mWr = '0; mErr = 0;
    endtask

    function automatic bit modelTake();
        return mBusy && vIn[mOwner] && (!mOv || oIn) && (mCred > 0);
    endfunction

    task automatic modelStep();
        bit take;
        bit found;
        int credNew;
        if (rstIn) begin
            modelReset();
            return;
        end
        take = modelTake();
        if (mOv && oIn) mWr = mWr + 64'd1;
        credNew = mCred - (take ? 1 : 0) + (crIn ? int'(cnIn) : 0);
        if (take) begin
            mOv = 1; mOd = dataIn[mOwner]; mOs = mOwner; mOl = lIn[mOwner];
        end else if (oIn) begin
            mOv = 0;
        end
        if (!mBusy) begin
            found = 0;
            for (int k = 0; k < NREQ; k++) begin
                if (!found && vIn[(mPtr + k) % NREQ]) begin
                    found  = 1;
                    mOwner = (mPtr + k) % NREQ;
                    mBusy  = 1;
                end
            end
        end else if (take && lIn[mOwner]) begin
            mBusy = 0;
            mPtr  = (mOwner + 1) % NREQ;
        end
        if (credNew > CREDITS) begin
            mCred = CREDITS;
            mErr  = 1;
        end else begin
            mCred = credNew;
        end
    endtask

    task automatic compareAll();
        logic [NREQ-1:0] expReady;
        expReady = '0;
        if (modelTake()) expReady[mOwner] = 1'b1;
        checkOutput("req_ready",  64'(bus.req_ready),  64'(expReady));
        checkOutput("out_valid",  64'(bus.out_valid),  64'(mOv));
        checkOutput("out_data",   64'(bus.out_data),   64'(mOd));
        checkOutput("out_src",    64'(bus.out_src),    64'(mOs));
        checkOutput("out_last",   64'(bus.out_last),   64'(mOl));
        checkOutput("credit_cnt", 64'(bus.credit_cnt), 64'(mCred));
        checkOutput("wr_cnt",     bus.wr_cnt,          mWr);
        checkOutput("credit_err", 64'(bus.credit_err), 64'(mErr));
    endtask

    // One cycle: drive at the falling edge, compare, then advance the model
    // to match what the DUT will register on the next rising edge.
    task automatic applyStimulus(input logic r, input logic [NREQ-1:0] v, input logic [NREQ-1:0] l,
                                 input logic o, input logic cr, input logic [CW-1:0] cn);
        @(negedge clk);
        rstIn = r; vIn = v; lIn = l; oIn = o; crIn = cr; cnIn = cn;
        for (int i = 0; i < NREQ; i++) begin
            dataIn[i] = DW'($urandom);
            bus.req_data[i*DW +: DW] = dataIn[i];
        end
        rst = r;
        bus.req_valid  = v;
        bus.req_last   = l;
        bus.out_ready  = o;
        bus.credit_ret = cr;
        bus.credit_num = cn;
        #1;
        compareAll();
        modelStep();
    endtask

    initial begin
        rst = 1'b1;
        bus.req_valid = '0; bus.req_last = '0; bus.req_data = '0;
        bus.out_ready = 1'b0; bus.credit_ret = 1'b0; bus.credit_num = '0;
        modelReset();
        @(posedge clk);
        applyStimulus(1, '0, '0, 1, 0, '0);
        applyStimulus(0, '0, '0, 1, 0, '0);
        checkOutput("rst_credit", 64'(bus.credit_cnt), 64'(CREDITS));
        checkOutput("rst_wrcnt",  bus.wr_cnt, 64'd0);
        checkOutput("rst_valid",  64'(bus.out_valid), 64'd0);

        // Single three-word message from requester 2.
        for (int c = 0; c < 6; c++) begin
            applyStimulus(0, (c < 4) ? 4'b0100 : 4'b0000, (c == 3) ? 4'b0100 : 4'b0000, 1, 0, '0);
            if (c >= 2 && c <= 4) begin
                checkOutput("msg_src",   64'(bus.out_src),   64'd2);
                checkOutput("msg_valid", 64'(bus.out_valid), 64'd1);
                checkOutput("msg_last",  64'(bus.out_last),  64'(c == 4));
            end
        end
        checkOutput("msg_wrcnt",  bus.wr_cnt, 64'd3);
        checkOutput("msg_credit", 64'(bus.credit_cnt), 64'(CREDITS - 3));

        // Credit exhaustion, resume on return, then overflow saturation.
        applyStimulus(1, '0, '0, 1, 0, '0);
        for (int c = 0; c < 12; c++) applyStimulus(0, 4'b0001, '0, 1, 0, '0);
        checkOutput("cred_zero",  64'(bus.credit_cnt), 64'd0);
        checkOutput("cred_stall", 64'(bus.req_ready),  64'd0);
        applyStimulus(0, 4'b0001, '0, 1, 1, CW'(2));
        applyStimulus(0, 4'b0001, '0, 1, 0, '0);
        checkOutput("cred_resume", 64'(bus.req_ready), 64'd1);
        applyStimulus(0, 4'b0001, 4'b0001, 1, 0, '0);
        applyStimulus(0, '0, '0, 1, 1, CW'(10));
        applyStimulus(0, '0, '0, 1, 0, '0);
        checkOutput("cred_sat", 64'(bus.credit_cnt), 64'(CREDITS));
        checkOutput("cred_err", 64'(bus.credit_err), 64'd1);

        // Randomized traffic with occasional mid-message resets.
        applyStimulus(1, '0, '0, 1, 0, '0);
        for (int c = 0; c < 4000; c++) begin
            logic [NREQ-1:0] v, l;
            for (int i = 0; i < NREQ; i++) begin
                v[i] = ($urandom_range(0, 99) < 75);
                l[i] = ($urandom_range(0, 99) < 35);
            end
            applyStimulus(($urandom_range(0, 299) == 0), v, l,
                          ($urandom_range(0, 99) < 70),
                          ($urandom_range(0, 99) < 20),
                          CW'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end
endmodule
